timestamp_reader: RTL and testbench



---
 rtl/timestamp_reader.sv | 204 ++++++++++++++++++++
 tb/tb_timestamp_reader.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/timestamp_reader.sv
// Avalon-MM initiator: coherent 64-bit capture (hi/lo/hi, retried) and 64-bit preload of a two-word timer.
// Latency: 3+3*READ_LATENCY cycles from cap_req to ts_valid, plus 2+2*READ_LATENCY per retry; a load takes 3 busy cycles.
// Backpressure: none; requests arriving while busy is high are dropped. `define TSR_DELTA_EN adds the ts_delta output.
module timestamp_reader #(
  parameter int READ_LATENCY = 1,
  parameter int MAX_RETRY    = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cap_req,
  input  logic        load_req,
  input  logic [63:0] load_value,
  output logic        busy,
  output logic        ts_valid,
  output logic [63:0] timestamp,
  output logic        ts_err,
  output logic [3:0]  retries,
  output logic        m_addr,
  output logic        m_read,
  output logic        m_write,
  output logic [31:0] m_writedata,
  input  logic [31:0] m_readdata
`ifdef TSR_DELTA_EN
  ,
  output logic [63:0] ts_delta
`endif
);

  typedef enum logic [3:0] {
    IDLE, RD_HI1, WT_HI1, RD_LO, WT_LO, RD_HI2, WT_HI2, WR_LO, WR_HI, DONE
  } state_t;

  localparam logic [1:0] LAT_LAST  = 2'(READ_LATENCY - 1);
  localparam logic [3:0] RETRY_MAX = 4'(MAX_RETRY);

  state_t      state_q, state_d;
  logic [1:0]  lat_q, lat_d;
  logic [3:0]  retry_q, retry_d;
  logic [31:0] hi1_q, hi1_d;
  logic [31:0] lo_q, lo_d;
  logic [63:0] ld_q, ld_d;
  logic        is_cap_q, is_cap_d;
  logic [63:0] ts_q, ts_d;
  logic        err_q, err_d;
  logic [3:0]  retries_q, retries_d;
  logic        busy_q, busy_d;
  logic        ts_valid_q, ts_valid_d;
  logic        m_addr_q, m_addr_d;
  logic        m_read_q, m_read_d;
  logic        m_write_q, m_write_d;
  logic [31:0] m_wdata_q, m_wdata_d;
  logic        wait_done;
  logic        load_acc;

  assign wait_done = (lat_q == LAT_LAST);

  // Next-state, datapath captures and registered-strobe decode of the next state.
  always_comb begin
    state_d   = state_q;
    lat_d     = lat_q;
    retry_d   = retry_q;
    hi1_d     = hi1_q;
    lo_d      = lo_q;
    ld_d      = ld_q;
    is_cap_d  = is_cap_q;
    ts_d      = ts_q;
    err_d     = err_q;
    retries_d = retries_q;
    load_acc  = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_req) begin
          ld_d     = load_value;
          is_cap_d = 1'b0;
          load_acc = 1'b1;
          state_d  = WR_LO;
        end else if (cap_req) begin
          retry_d  = 4'd0;
          is_cap_d = 1'b1;
          state_d  = RD_HI1;
        end
      end
      RD_HI1: begin lat_d = 2'd0; state_d = WT_HI1; end
      RD_LO:  begin lat_d = 2'd0; state_d = WT_LO;  end
      RD_HI2: begin lat_d = 2'd0; state_d = WT_HI2; end
      WT_HI1: begin
        if (wait_done) begin
          hi1_d   = m_readdata;
          state_d = RD_LO;
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end
      WT_LO: begin
        if (wait_done) begin
          lo_d    = m_readdata;
          state_d = RD_HI2;
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end
      WT_HI2: begin
        if (!wait_done) begin
          lat_d = lat_q + 2'd1;
        end else if (m_readdata != hi1_q && retry_q < RETRY_MAX) begin
          // High word moved under us: rescan the low word against the new high word.
          retry_d = retry_q + 4'd1;
          hi1_d   = m_readdata;
          state_d = RD_LO;
        end else begin
          ts_d      = {m_readdata, lo_q};
          err_d     = (m_readdata != hi1_q);
          retries_d = retry_q;
          state_d   = DONE;
        end
      end
      WR_LO:   state_d = WR_HI;
      WR_HI:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    m_read_d   = (state_d == RD_HI1) || (state_d == RD_LO) || (state_d == RD_HI2);
    m_write_d  = (state_d == WR_LO) || (state_d == WR_HI);
    m_addr_d   = (state_d == RD_HI1) || (state_d == RD_HI2) || (state_d == WR_HI);
    m_wdata_d  = (state_d == WR_LO) ? ld_d[31:0] :
                 (state_d == WR_HI) ? ld_d[63:32] : 32'd0;
    busy_d     = (state_d != IDLE);
    ts_valid_d = (state_d == DONE) && (state_q == WT_HI2);
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      lat_q      <= 2'd0;
      retry_q    <= 4'd0;
      hi1_q      <= 32'd0;
      lo_q       <= 32'd0;
      ld_q       <= 64'd0;
      is_cap_q   <= 1'b0;
      ts_q       <= 64'd0;
      err_q      <= 1'b0;
      retries_q  <= 4'd0;
      busy_q     <= 1'b0;
      ts_valid_q <= 1'b0;
      m_addr_q   <= 1'b0;
      m_read_q   <= 1'b0;
      m_write_q  <= 1'b0;
      m_wdata_q  <= 32'd0;
    end else begin
      state_q    <= state_d;
      lat_q      <= lat_d;
      retry_q    <= retry_d;
      hi1_q      <= hi1_d;
      lo_q       <= lo_d;
      ld_q       <= ld_d;
      is_cap_q   <= is_cap_d;
      ts_q       <= ts_d;
      err_q      <= err_d;
      retries_q  <= retries_d;
      busy_q     <= busy_d;
      ts_valid_q <= ts_valid_d;
      m_addr_q   <= m_addr_d;
      m_read_q   <= m_read_d;
      m_write_q  <= m_write_d;
      m_wdata_q  <= m_wdata_d;
    end
  end

`ifdef TSR_DELTA_EN
  logic [63:0] ref_q;
  logic        ref_vld_q;
  logic [63:0] delta_q;

  // Delta against the previous capture; a load invalidates the reference.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ref_q     <= 64'd0;
      ref_vld_q <= 1'b0;
      delta_q   <= 64'd0;
    end else if (load_acc) begin
      ref_vld_q <= 1'b0;
    end else if (ts_valid_d) begin
      delta_q   <= ref_vld_q ? (ts_d - ref_q) : 64'd0;
      ref_q     <= ts_d;
      ref_vld_q <= 1'b1;
    end
  end

  assign ts_delta = delta_q;
`endif

  assign busy        = busy_q;
  assign ts_valid    = ts_valid_q;
  assign timestamp   = ts_q;
  assign ts_err      = err_q;
  assign retries     = retries_q;
  assign m_addr      = m_addr_q;
  assign m_read      = m_read_q;
  assign m_write     = m_write_q;
  assign m_writedata = m_wdata_q;

endmodule

// File: tb/tb_timestamp_reader.sv
// Directed bench for timestamp_reader: timer responder (+1 per cycle, registered read data, write replaces a half).
// Cycle numbers are edges counted from the edge that samples the request (that edge is cycle 0).
// Outputs are sampled 1 time unit after each rising edge.
module tb_timestamp_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cap_req = 1'b0;
  logic        load_req = 1'b0;
  logic [63:0] load_value = 64'd0;
  logic        busy, ts_valid, ts_err, m_addr, m_read, m_write;
  logic [63:0] timestamp;
  logic [3:0]  retries;
  logic [31:0] m_writedata;
  logic [31:0] m_readdata;
`ifdef TSR_DELTA_EN
  logic [63:0] ts_delta;
`endif

  timestamp_reader #(.READ_LATENCY(1), .MAX_RETRY(3)) dut (
    .clk(clk), .rst_n(rst_n), .cap_req(cap_req), .load_req(load_req),
    .load_value(load_value), .busy(busy), .ts_valid(ts_valid),
    .timestamp(timestamp), .ts_err(ts_err), .retries(retries),
    .m_addr(m_addr), .m_read(m_read), .m_write(m_write),
    .m_writedata(m_writedata), .m_readdata(m_readdata)
`ifdef TSR_DELTA_EN
    , .ts_delta(ts_delta)
`endif
  );

  always #5 clk = ~clk;

  // Timer responder; preset_stb loads the timer (and the bump counter) directly.
  logic        preset_stb = 1'b0;
  logic [63:0] preset_val = 64'd0;
  logic        bump_en = 1'b0;
  logic [31:0] bump_init = 32'd0;
  logic [63:0] t_q = 64'd0;
  logic [31:0] bump_q = 32'd0;
  logic [31:0] rdata_q = 32'd0;

  assign m_readdata = rdata_q;

  always @(posedge clk) begin
    if (m_read)
      rdata_q <= (m_addr && bump_en) ? bump_q : (m_addr ? t_q[63:32] : t_q[31:0]);
    if (preset_stb) begin
      t_q    <= preset_val;
      bump_q <= bump_init;
    end else begin
      if (m_read && m_addr && bump_en) bump_q <= bump_q + 32'd1;
      if (m_write) t_q <= m_addr ? {m_writedata, t_q[31:0]} : {t_q[63:32], m_writedata};
      else         t_q <= t_q + 64'd1;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;
  int cyc, n_tv, tv_cyc;
  bit          rd_q[$];
  bit          wr_a[$];
  logic [31:0] wr_d[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (m_read) rd_q.push_back(m_addr);
    if (m_write) begin
      wr_a.push_back(m_addr);
      wr_d.push_back(m_writedata);
    end
    if (ts_valid) begin
      n_tv++;
      tv_cyc = cyc;
    end
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic issue(input logic cap, input logic ld, input logic [63:0] lv,
                       input logic pre, input logic [63:0] pv);
    rd_q.delete(); wr_a.delete(); wr_d.delete();
    n_tv = 0; tv_cyc = -1; cyc = -1;
    cap_req = cap; load_req = ld; load_value = lv;
    preset_stb = pre; preset_val = pv;
    tick();
    cap_req = 1'b0; load_req = 1'b0; preset_stb = 1'b0;
  endtask

  function automatic logic [2:0] rd3();
    logic [2:0] v;
    v = 3'd0;
    if (rd_q.size() == 3) v = {rd_q[0], rd_q[1], rd_q[2]};
    return v;
  endfunction

  initial begin
    // Reset state
    run(3);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_strobes", {61'd0, m_read, m_write, m_addr}, 64'd0);
    chk("rst_ts", timestamp, 64'd0);
    chk("rst_misc", {27'd0, ts_valid, ts_err, retries, m_writedata}, 64'd0);
    rst_n = 1'b1;
    run(2);

    // Plain capture
    issue(1'b1, 1'b0, 64'd0, 1'b1, 64'h0000_0007_0000_0100);
    chk("cap_busy", {63'd0, busy}, 64'd1);
    run(10);
    chk("cap_nreads", rd_q.size(), 64'd3);
    chk("cap_addrs", {61'd0, rd3()}, 64'b101);
    chk("cap_tv_cyc", 64'(tv_cyc), 64'd6);
    chk("cap_tv_cnt", 64'(n_tv), 64'd1);
    chk("cap_ts", timestamp, 64'h0000_0007_0000_0102);
    chk("cap_err_ret", {59'd0, ts_err, retries}, 64'd0);
    chk("cap_idle", {63'd0, busy}, 64'd0);

    // Low-word wrap between reads forces one retry
    issue(1'b1, 1'b0, 64'd0, 1'b1, 64'h0000_0002_FFFF_FFFE);
    run(14);
    chk("wrap_tv_cyc", 64'(tv_cyc), 64'd10);
    chk("wrap_ts", timestamp, 64'h0000_0003_0000_0004);
    chk("wrap_retries", {60'd0, retries}, 64'd1);
    chk("wrap_err", {63'd0, ts_err}, 64'd0);
    chk("wrap_nreads", rd_q.size(), 64'd5);

    // Load, then a capture reads back the loaded value
    issue(1'b0, 1'b1, 64'h1234_5678_9ABC_DEF0, 1'b0, 64'd0);
    run(6);
    chk("ld_nwrites", wr_a.size(), 64'd2);
    chk("ld_w0", {31'd0, wr_a[0], wr_d[0]}, {32'd0, 32'h9ABC_DEF0});
    chk("ld_w1", {31'd0, wr_a[1], wr_d[1]}, {31'd0, 1'b1, 32'h1234_5678});
    chk("ld_no_tv", 64'(n_tv), 64'd0);
    chk("ld_no_reads", rd_q.size(), 64'd0);
    issue(1'b1, 1'b0, 64'd0, 1'b0, 64'd0);
    run(10);
    chk("ld_cap_ts", timestamp, 64'h1234_5678_9ABC_DEF7);

    // load_req beats a simultaneous cap_req
    issue(1'b1, 1'b1, 64'hAAAA_BBBB_CCCC_DDDD, 1'b0, 64'd0);
    run(8);
    chk("pri_nreads", rd_q.size(), 64'd0);
    chk("pri_nwrites", wr_a.size(), 64'd2);
    chk("pri_w0", {32'd0, wr_d[0]}, {32'd0, 32'hCCCC_DDDD});
    chk("pri_no_tv", 64'(n_tv), 64'd0);

    // cap_req while busy is dropped
    issue(1'b1, 1'b0, 64'd0, 1'b1, 64'h0000_0009_0000_0000);
    run(2);
    cap_req = 1'b1;
    tick();
    cap_req = 1'b0;
    run(12);
    chk("busy_nreads", rd_q.size(), 64'd3);
    chk("busy_tv_cnt", 64'(n_tv), 64'd1);

    // High word changes on every read: retry budget exhausted
    bump_en = 1'b1;
    bump_init = 32'h0000_0100;
    issue(1'b1, 1'b0, 64'd0, 1'b1, 64'h0000_0000_0000_1000);
    run(22);
    bump_en = 1'b0;
    chk("exh_tv_cyc", 64'(tv_cyc), 64'd18);
    chk("exh_tv_cnt", 64'(n_tv), 64'd1);
    chk("exh_err", {63'd0, ts_err}, 64'd1);
    chk("exh_retries", {60'd0, retries}, 64'd3);
    chk("exh_ts", timestamp, 64'h0000_0104_0000_100E);
    chk("exh_nreads", rd_q.size(), 64'd9);

    // Reset while in WT_LO aborts the capture
    issue(1'b1, 1'b0, 64'd0, 1'b1, 64'h0000_0005_0000_0000);
    run(3);
    rst_n = 1'b0;
    tick();
    chk("arst_busy", {63'd0, busy}, 64'd0);
    chk("arst_strobes", {62'd0, m_read, m_write}, 64'd0);
    chk("arst_ts", timestamp, 64'd0);
    rst_n = 1'b1;
    tick();
    chk("arst_post_strobes", {62'd0, m_read, m_write}, 64'd0);
    run(8);
    chk("arst_nreads", rd_q.size(), 64'd2);
    chk("arst_no_tv", 64'(n_tv), 64'd0);
    issue(1'b1, 1'b0, 64'd0, 1'b1, 64'h0000_0005_0000_0010);
    run(10);
    chk("arst_cap_tv_cyc", 64'(tv_cyc), 64'd6);
    chk("arst_cap_ts", timestamp, 64'h0000_0005_0000_0012);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
